// File: rtl/timer_pkg.sv
// Shared types and constants for the millisecond timer and its delay controller.
package timer_pkg;

  localparam int MS_W         = 13;
  localparam int REQ_MS_W     = 16;
  localparam int TAG_W        = 4;
  // Largest ms value whose tick count (value * CLK_PER_MS) still fits in 28 bits.
  localparam int CHUNK_MS_MAX = 5368;
  localparam int CLK_PER_MS   = 50000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    WAIT,
    CLEAR,
    DONE
  } state_t;

  function automatic logic [REQ_MS_W-1:0] min_ms(input logic [REQ_MS_W-1:0] a,
                                                 input logic [REQ_MS_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty flags and a flush that beats push/pop.
module req_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q && !flush;
    do_pop   = pop && !empty_q && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + (AW + 1)'(1);
      else if (do_pop && !do_push) count_d = count_q - (AW + 1)'(1);
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/timer_delay_ctrl.sv
// Queues CPU delay requests, drives the ms timer chunk by chunk and reports completion by tag.
module timer_delay_ctrl
  import timer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int CHUNK_MS = 5000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [REQ_MS_W-1:0] req_ms,
  input  logic [TAG_W-1:0]    req_tag,
  input  logic                abort,
  output logic                done_valid,
  output logic [TAG_W-1:0]    done_tag,
  output logic                busy,
  output logic [MS_W-1:0]     tmr_ms,
  input  logic                tmr_rdy
);

  localparam int ENTRY_W = REQ_MS_W + TAG_W;
  // An oversized CHUNK_MS is clamped so the timer count can never overflow.
  localparam int CHUNK_EFF = (CHUNK_MS > CHUNK_MS_MAX) ? CHUNK_MS_MAX : CHUNK_MS;
  localparam logic [REQ_MS_W-1:0] CHUNK = REQ_MS_W'(CHUNK_EFF);

  state_t              state_q, state_d;
  logic [REQ_MS_W-1:0] remaining_q, remaining_d;
  logic [TAG_W-1:0]    cur_tag_q, cur_tag_d;
  logic [MS_W-1:0]     tmr_ms_q, tmr_ms_d;
  logic                done_valid_q, done_valid_d;
  logic [TAG_W-1:0]    done_tag_q, done_tag_d;
  logic                aborted_q, aborted_d;
  logic [REQ_MS_W-1:0] chunk;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  fifo_rdata;

  assign fifo_push = req_valid && req_ready;

  req_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_req_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .flush(abort),
    .wdata({req_ms, req_tag}),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    cur_tag_d    = cur_tag_q;
    tmr_ms_d     = tmr_ms_q;
    done_valid_d = 1'b0;
    done_tag_d   = done_tag_q;
    aborted_d    = aborted_q;
    fifo_pop     = 1'b0;
    chunk        = min_ms(remaining_q, CHUNK);

    if (abort) begin
      remaining_d = '0;
      tmr_ms_d    = '0;
      // A programmed timer must be seen to drop rdy before anything new is armed.
      if (state_q == ARM || state_q == WAIT) begin
        state_d   = CLEAR;
        aborted_d = 1'b1;
      end else begin
        state_d   = IDLE;
        aborted_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            remaining_d = fifo_rdata[ENTRY_W-1:TAG_W];
            cur_tag_d   = fifo_rdata[TAG_W-1:0];
            state_d     = LOAD;
          end
        end
        LOAD: state_d = (remaining_q == '0) ? DONE : ARM;
        ARM: begin
          tmr_ms_d    = chunk[MS_W-1:0];
          remaining_d = remaining_q - chunk;
          state_d     = WAIT;
        end
        WAIT: begin
          if (tmr_rdy) begin
            tmr_ms_d = '0;
            state_d  = CLEAR;
          end
        end
        CLEAR: begin
          tmr_ms_d = '0;
          if (!tmr_rdy) begin
            aborted_d = 1'b0;
            if (aborted_q)                state_d = IDLE;
            else if (remaining_q != '0)   state_d = LOAD;
            else                          state_d = DONE;
          end
        end
        DONE: begin
          done_valid_d = 1'b1;
          done_tag_d   = cur_tag_q;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      cur_tag_q    <= '0;
      tmr_ms_q     <= '0;
      done_valid_q <= 1'b0;
      done_tag_q   <= '0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      cur_tag_q    <= cur_tag_d;
      tmr_ms_q     <= tmr_ms_d;
      done_valid_q <= done_valid_d;
      done_tag_q   <= done_tag_d;
      aborted_q    <= aborted_d;
    end
  end

  assign req_ready  = !fifo_full;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign tmr_ms     = tmr_ms_q;
  assign done_valid = done_valid_q;
  assign done_tag   = done_tag_q;

endmodule

// File: tb/tb_timer_delay_ctrl.sv
// Directed bench for timer_delay_ctrl with a stub timer and a full-count timer model.
module tb_timer_delay_ctrl;
  import timer_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [REQ_MS_W-1:0] req_ms = '0;
  logic [TAG_W-1:0]    req_tag = '0;
  logic                abort = 1'b0;
  logic                done_valid;
  logic [TAG_W-1:0]    done_tag;
  logic                busy;
  logic [MS_W-1:0]     tmr_ms;
  logic                tmr_rdy = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int  k_stub    = 20;
  bit  real_mode = 1'b0;
  int  tcnt      = 0;

  int              tmr_seq[$];
  int              tmr_cyc[$];
  logic [TAG_W-1:0] done_tags[$];
  int              done_cycles[$];
  logic [MS_W-1:0] last_tmr = '0;

  timer_delay_ctrl #(.DEPTH(4), .CHUNK_MS(5000)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ms    (req_ms),
    .req_tag   (req_tag),
    .abort     (abort),
    .done_valid(done_valid),
    .done_tag  (done_tag),
    .busy      (busy),
    .tmr_ms    (tmr_ms),
    .tmr_rdy   (tmr_rdy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int k_eff();
    return real_mode ? int'(tmr_ms) * CLK_PER_MS : k_stub;
  endfunction

  // Timer model: rdy latches K edges after a nonzero ms value, drops the edge after ms = 0.
  always @(posedge clk) begin
    if (tmr_ms == '0) begin
      tmr_rdy <= 1'b0;
      tcnt    <= 0;
    end else if (!tmr_rdy) begin
      tcnt <= tcnt + 1;
      if (tcnt + 1 >= k_eff()) tmr_rdy <= 1'b1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (tmr_ms != last_tmr) begin
      tmr_seq.push_back(int'(tmr_ms));
      tmr_cyc.push_back(cyc);
      last_tmr = tmr_ms;
    end
    if (done_valid) begin
      done_tags.push_back(done_tag);
      done_cycles.push_back(cyc);
    end
  end

  task automatic clear_logs();
    tmr_seq.delete();
    tmr_cyc.delete();
    done_tags.delete();
    done_cycles.delete();
  endtask

  task automatic push_one(input int ms, input int tag, output int pcyc);
    @(negedge clk);
    req_valid = 1'b1;
    req_ms    = REQ_MS_W'(ms);
    req_tag   = TAG_W'(tag);
    @(negedge clk);
    req_valid = 1'b0;
    pcyc      = cyc;
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    for (int i = 0; i < budget && done_tags.size() < n; i++) @(negedge clk);
    n_checks++;
    if (done_tags.size() < n)
      $display("[TB] FAIL %s timeout: completions=%0d required=%0d", name, done_tags.size(), n);
    else n_pass++;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("[TB] FAIL idle_timeout: busy=%b required=0", busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (tmr_ms !== '0) $display("[TB] FAIL rst_tmr_ms: got %0d want 0", tmr_ms); else n_pass++;
    n_checks++; if (done_valid !== 1'b0) $display("[TB] FAIL rst_done_valid: got %b want 0", done_valid); else n_pass++;
    n_checks++; if (done_tag !== '0) $display("[TB] FAIL rst_done_tag: got %0d want 0", done_tag); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("[TB] FAIL rst_req_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", busy); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int p;
    k_stub = 20;
    clear_logs();
    push_one(7, 3, p);
    repeat (2) @(negedge clk);
    n_checks++; if (tmr_ms !== '0) $display("[TB] FAIL single_tmr_early: got %0d want 0", tmr_ms); else n_pass++;
    @(negedge clk);
    n_checks++; if (tmr_ms !== 13'd7) $display("[TB] FAIL single_tmr_armed: got %0d want 7", tmr_ms); else n_pass++;
    wait_done(1, 100, "single_done");
    repeat (5) @(negedge clk);
    n_checks++; if (done_tags.size() != 1) $display("[TB] FAIL single_done_count: got %0d want 1", done_tags.size()); else n_pass++;
    if (done_tags.size() >= 1) begin
      n_checks++; if (done_tags[0] !== 4'd3) $display("[TB] FAIL single_done_tag: got %0d want 3", done_tags[0]); else n_pass++;
      n_checks++; if (done_cycles[0] != p + 27) $display("[TB] FAIL single_done_time: got %0d want %0d", done_cycles[0] - p, 27); else n_pass++;
    end
    n_checks++;
    if (tmr_seq.size() != 2 || tmr_seq[0] != 7 || tmr_seq[1] != 0)
      $display("[TB] FAIL single_tmr_seq: got size %0d want {7,0}", tmr_seq.size());
    else n_pass++;
    n_checks++; if (done_tag !== 4'd3) $display("[TB] FAIL single_tag_hold: got %0d want 3", done_tag); else n_pass++;
  endtask

  task automatic test_chunked();
    int p;
    int exp_seq[6] = '{5000, 0, 5000, 0, 2000, 0};
    k_stub = 5;
    clear_logs();
    push_one(12000, 1, p);
    wait_done(1, 300, "chunk_done");
    wait_idle(20);
    repeat (3) @(negedge clk);
    n_checks++; if (tmr_seq.size() != 6) $display("[TB] FAIL chunk_seq_len: got %0d want 6", tmr_seq.size()); else n_pass++;
    for (int i = 0; i < 6 && i < tmr_seq.size(); i++) begin
      n_checks++;
      if (tmr_seq[i] != exp_seq[i]) $display("[TB] FAIL chunk_seq_%0d: got %0d want %0d", i, tmr_seq[i], exp_seq[i]);
      else n_pass++;
    end
    n_checks++; if (done_tags.size() != 1) $display("[TB] FAIL chunk_done_count: got %0d want 1", done_tags.size()); else n_pass++;
    if (done_tags.size() >= 1) begin
      n_checks++; if (done_tags[0] !== 4'd1) $display("[TB] FAIL chunk_done_tag: got %0d want 1", done_tags[0]); else n_pass++;
    end
  endtask

  task automatic test_zero_ms();
    int p;
    clear_logs();
    push_one(0, 9, p);
    wait_done(1, 20, "zero_done");
    if (done_tags.size() >= 1) begin
      n_checks++; if (done_cycles[0] != p + 3) $display("[TB] FAIL zero_done_time: got %0d want 3", done_cycles[0] - p); else n_pass++;
      n_checks++; if (done_tags[0] !== 4'd9) $display("[TB] FAIL zero_done_tag: got %0d want 9", done_tags[0]); else n_pass++;
    end
    n_checks++; if (tmr_seq.size() != 0) $display("[TB] FAIL zero_tmr_touched: got %0d changes want 0", tmr_seq.size()); else n_pass++;
    wait_idle(10);
  endtask

  task automatic test_back_to_back();
    int ms_v[5] = '{1, 2, 0, 3, 1};
    k_stub = 10;
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) $display("[TB] FAIL b2b_ready_before_push%0d: got %b want 1", i, req_ready);
      else n_pass++;
      req_valid = 1'b1;
      req_ms    = REQ_MS_W'(ms_v[i]);
      req_tag   = TAG_W'(10 + i);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (req_ready !== 1'b0) $display("[TB] FAIL b2b_full: got %b want 0", req_ready); else n_pass++;
    repeat (6) @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) $display("[TB] FAIL b2b_full_hold: got %b want 0", req_ready); else n_pass++;
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("[TB] FAIL b2b_ready_return: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (done_tags.size() != 1) $display("[TB] FAIL b2b_first_done: got %0d want 1", done_tags.size()); else n_pass++;
    wait_done(5, 500, "b2b_all_done");
    for (int i = 0; i < 5 && i < done_tags.size(); i++) begin
      n_checks++;
      if (done_tags[i] !== TAG_W'(10 + i)) $display("[TB] FAIL b2b_order_%0d: got %0d want %0d", i, done_tags[i], 10 + i);
      else n_pass++;
    end
    wait_idle(20);
  endtask

  task automatic test_abort();
    int p;
    k_stub = 100;
    clear_logs();
    push_one(5, 4, p);
    push_one(6, 5, p);
    push_one(7, 6, p);
    for (int i = 0; i < 20 && tmr_ms != 13'd5; i++) @(negedge clk);
    n_checks++; if (tmr_ms !== 13'd5) $display("[TB] FAIL abort_armed: got %0d want 5", tmr_ms); else n_pass++;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (tmr_ms !== '0) $display("[TB] FAIL abort_tmr_zero: got %0d want 0", tmr_ms); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("[TB] FAIL abort_fifo_flushed: ready=%b want 1", req_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy_after_clear: got %b want 0", busy); else n_pass++;
    repeat (30) @(negedge clk);
    n_checks++; if (done_tags.size() != 0) $display("[TB] FAIL abort_no_done: got %0d want 0", done_tags.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_stays_idle: got %b want 0", busy); else n_pass++;
    n_checks++; if (tmr_seq.size() != 2) $display("[TB] FAIL abort_tmr_seq: got %0d changes want 2", tmr_seq.size()); else n_pass++;
  endtask

  task automatic test_real_timer();
    int p;
    int lat;
    real_mode = 1'b1;
    clear_logs();
    push_one(1, 2, p);
    wait_done(1, 50200, "real_done");
    if (done_tags.size() >= 1 && tmr_cyc.size() >= 1) begin
      lat = done_cycles[0] - tmr_cyc[0];
      n_checks++;
      if (lat < 50000 || lat > 50010) $display("[TB] FAIL real_latency: got %0d want 50000..50010", lat);
      else n_pass++;
      n_checks++; if (done_tags[0] !== 4'd2) $display("[TB] FAIL real_done_tag: got %0d want 2", done_tags[0]); else n_pass++;
    end
    wait_idle(20);
    push_one(2, 7, p);
    for (int i = 0; i < 20 && tmr_ms != 13'd2; i++) @(negedge clk);
    n_checks++; if (tmr_ms !== 13'd2) $display("[TB] FAIL midrst_armed: got %0d want 2", tmr_ms); else n_pass++;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (tmr_ms !== '0) $display("[TB] FAIL midrst_tmr_ms: got %0d want 0", tmr_ms); else n_pass++;
    n_checks++; if (done_valid !== 1'b0) $display("[TB] FAIL midrst_done_valid: got %b want 0", done_valid); else n_pass++;
    n_checks++; if (done_tag !== '0) $display("[TB] FAIL midrst_done_tag: got %0d want 0", done_tag); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("[TB] FAIL midrst_req_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    rst = 1'b0;
    real_mode = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    $display("[TB] timer_delay_ctrl bench start (chunk max %0d ms)", CHUNK_MS_MAX);
    test_reset();
    test_single();
    test_chunked();
    test_zero_ms();
    test_back_to_back();
    test_abort();
    test_real_timer();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
